// File: rtl/fifo_pkg.sv
// Shared constants and mode encodings for the single-clock programmable FIFO.
package fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEPTH          = 2 ** DEF_ADDR_WIDTH;
  localparam int unsigned LEVEL_W        = DEF_ADDR_WIDTH + 1;

  typedef enum logic {
    MODE_REG  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write port, asynchronous read by address.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned MEM_DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // NOTE: storage has no reset; only pointers and Level decide what is valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with registered or first-word-fall-through output, fill level,
// programmable almost-full/almost-empty thresholds, sticky error flags and flush.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Flush,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Wr_enable,
  input  logic                  Read_enable,
  input  logic [ADDR_WIDTH:0]   AlmostFull_level,
  input  logic [ADDR_WIDTH:0]   AlmostEmpty_level,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic [ADDR_WIDTH:0]   Level,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostFull,
  output logic                  AlmostEmpty,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam fifo_mode_e            MODE    = (FWFT != 0) ? MODE_FWFT : MODE_REG;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LVL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  rd_acc, wr_acc;

  // A read frees a slot this cycle, so a full FIFO may still take a write.
  assign rd_acc = Read_enable & ~Empty;
  assign wr_acc = Wr_enable & (~Full | rd_acc);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc & ~Flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (DataIn),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dout_d   = dout_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      dout_d   = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        dout_d   = head_data;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      if (Wr_enable & ~wr_acc)   ovf_d = 1'b1;
      if (Read_enable & ~rd_acc) unf_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  assign Level       = level_q;
  assign Empty       = (level_q == '0);
  assign Full        = (level_q == DEPTH_L);
  assign AlmostFull  = (level_q >= AlmostFull_level);
  assign AlmostEmpty = (level_q <= AlmostEmpty_level);
  assign Overflow    = ovf_q;
  assign Underflow   = unf_q;
  assign DataOut     = (MODE == MODE_FWFT) ? head_data : dout_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a registered-read and an FWFT instance with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_sync_fifo_prog;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, wr, rd;
  logic [DW-1:0] din;
  logic [AW:0]   af_lvl, ae_lvl;

  logic [DW-1:0] dout0, dout1;
  logic [AW:0]   level0, level1;
  logic          empty0, full0, af0, ae0, ovf0, unf0;
  logic          empty1, full1, af1, ae1, ovf1, unf1;

  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf;
  logic [DW-1:0] m_dout;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .Flush(flush), .DataIn(din), .Wr_enable(wr),
    .Read_enable(rd), .AlmostFull_level(af_lvl), .AlmostEmpty_level(ae_lvl),
    .DataOut(dout0), .Level(level0), .Empty(empty0), .Full(full0),
    .AlmostFull(af0), .AlmostEmpty(ae0), .Overflow(ovf0), .Underflow(unf0));

  sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .Flush(flush), .DataIn(din), .Wr_enable(wr),
    .Read_enable(rd), .AlmostFull_level(af_lvl), .AlmostEmpty_level(ae_lvl),
    .DataOut(dout1), .Level(level1), .Empty(empty1), .Full(full1),
    .AlmostFull(af1), .AlmostEmpty(ae1), .Overflow(ovf1), .Underflow(unf1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = '0;
  endtask

  task automatic model_step(input bit fl, input bit w, input bit r, input logic [DW-1:0] d);
    bit r_ok, w_ok;
    if (fl) begin
      model_reset();
    end else begin
      r_ok = r && (mq.size() > 0);
      w_ok = w && ((mq.size() < D) || r_ok);
      if (r_ok) m_dout = mq.pop_front();
      if (w_ok) mq.push_back(d);
      if (w && !w_ok) m_ovf = 1'b1;
      if (r && !r_ok) m_unf = 1'b1;
    end
  endtask

  task automatic check_all(input string ph);
    int lvl;
    lvl = mq.size();
    check({ph, " reg Level"},       32'(level0), 32'(lvl));
    check({ph, " reg Empty"},       32'(empty0), 32'(lvl == 0));
    check({ph, " reg Full"},        32'(full0),  32'(lvl == D));
    check({ph, " reg AlmostFull"},  32'(af0),    32'(lvl >= int'(af_lvl)));
    check({ph, " reg AlmostEmpty"}, 32'(ae0),    32'(lvl <= int'(ae_lvl)));
    check({ph, " reg Overflow"},    32'(ovf0),   32'(m_ovf));
    check({ph, " reg Underflow"},   32'(unf0),   32'(m_unf));
    check({ph, " reg DataOut"},     32'(dout0),  32'(m_dout));
    check({ph, " fwft Level"},      32'(level1), 32'(lvl));
    check({ph, " fwft Empty"},      32'(empty1), 32'(lvl == 0));
    check({ph, " fwft Full"},       32'(full1),  32'(lvl == D));
    check({ph, " fwft AlmostFull"}, 32'(af1),    32'(lvl >= int'(af_lvl)));
    check({ph, " fwft AlmostEmpty"},32'(ae1),    32'(lvl <= int'(ae_lvl)));
    check({ph, " fwft Overflow"},   32'(ovf1),   32'(m_ovf));
    check({ph, " fwft Underflow"},  32'(unf1),   32'(m_unf));
    if (lvl > 0) check({ph, " fwft DataOut"}, 32'(dout1), 32'(mq[0]));
  endtask

  task automatic cyc(input string ph, input bit fl, input bit w, input bit r,
                     input logic [DW-1:0] d);
    flush = fl;
    wr    = w;
    rd    = r;
    din   = d;
    @(posedge clk);
    model_step(fl, w, r, d);
    #1;
    check_all(ph);
  endtask

  initial begin
    rst    = 1'b1;
    flush  = 1'b0;
    wr     = 1'b0;
    rd     = 1'b0;
    din    = '0;
    af_lvl = 6'd28;
    ae_lvl = 6'd3;
    model_reset();
    #12;
    check_all("reset");
    check("reset AlmostEmpty", 32'(ae0), 32'd1);
    check("reset AlmostFull",  32'(af0), 32'd0);
    rst = 1'b0;

    // Registered-read basic ordering and underflow
    cyc("w55", 1'b0, 1'b1, 1'b0, 8'h55);
    cyc("w81", 1'b0, 1'b1, 1'b0, 8'h81);
    cyc("r1",  1'b0, 1'b0, 1'b1, 8'h00);
    check("first read data", 32'(dout0), 32'h55);
    cyc("r2",  1'b0, 1'b0, 1'b1, 8'h00);
    check("second read data", 32'(dout0), 32'h81);
    check("empty after drain", 32'(empty0), 32'd1);
    cyc("r3",  1'b0, 1'b0, 1'b1, 8'h00);
    check("underflow sticky", 32'(unf0), 32'd1);
    cyc("flush_a", 1'b1, 1'b0, 1'b0, 8'h00);
    check("flush clears underflow", 32'(unf0), 32'd0);

    // Fill, simultaneous rd+wr on full, overflow, drain
    for (int i = 0; i < D; i++) cyc("fill", 1'b0, 1'b1, 1'b0, 8'(i));
    check("full at 32", 32'(full0), 32'd1);
    check("level 32", 32'(level0), 32'd32);
    cyc("rdwr_full", 1'b0, 1'b1, 1'b1, 8'h77);
    check("rdwr full level", 32'(level0), 32'd32);
    check("rdwr full no overflow", 32'(ovf0), 32'd0);
    cyc("ovf", 1'b0, 1'b1, 1'b0, 8'hAA);
    check("overflow set", 32'(ovf0), 32'd1);
    for (int i = 0; i < D; i++) cyc("drain", 1'b0, 1'b0, 1'b1, 8'h00);
    check("last word 77", 32'(dout0), 32'h77);
    check("drained empty", 32'(empty0), 32'd1);

    // Threshold crossings while filling and draining
    cyc("flush_b", 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= D; i++) begin
      cyc("thr_fill", 1'b0, 1'b1, 1'b0, 8'($urandom));
      check("thr_fill AE", 32'(ae0), 32'(i <= 3));
      check("thr_fill AF", 32'(af0), 32'(i >= 28));
    end
    for (int i = D - 1; i >= 0; i--) begin
      cyc("thr_drain", 1'b0, 1'b0, 1'b1, 8'h00);
      check("thr_drain AE", 32'(ae1), 32'(i <= 3));
      check("thr_drain AF", 32'(af1), 32'(i >= 28));
    end
    af_lvl = 6'd0;
    #1;
    check("AF level 0 immediate", 32'(af0), 32'd1);
    af_lvl = 6'd28;
    #1;
    check_all("thr_restore");

    // FWFT fall-through and flush with requests pending
    cyc("fw_w3c", 1'b0, 1'b1, 1'b0, 8'h3C);
    check("fwft head visible", 32'(dout1), 32'h3C);
    check("fwft not empty", 32'(empty1), 32'd0);
    for (int i = 0; i < 5; i++) cyc("fw_w5", 1'b0, 1'b1, 1'b0, 8'($urandom));
    cyc("fw_flush", 1'b1, 1'b1, 1'b1, 8'h99);
    check("flush level", 32'(level1), 32'd0);
    check("flush no overflow", 32'(ovf1), 32'd0);
    check("flush no underflow", 32'(unf1), 32'd0);
    check("flush reg dataout", 32'(dout0), 32'd0);

    // Randomised traffic with varying bias, occasional flush and threshold changes
    for (int i = 0; i < 800; i++) begin
      int wp, rp;
      wp = ((i / 100) % 2 == 0) ? 70 : 35;
      rp = 100 - wp;
      if (i % 40 == 0) begin
        af_lvl = 6'($urandom_range(0, 33));
        ae_lvl = 6'($urandom_range(0, 33));
      end
      cyc("rand", ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), 8'($urandom));
    end

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 4; i++) cyc("pre_rst", 1'b0, 1'b1, 1'b0, 8'($urandom));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst = 1'b0;
    cyc("post_rst_w", 1'b0, 1'b1, 1'b0, 8'hE7);
    cyc("post_rst_r", 1'b0, 1'b0, 1'b1, 8'h00);
    check("post reset read", 32'(dout0), 32'hE7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO in this codebase for same-domain buffering. It adds a selectable output mode, either registered-read or first-word-fall-through (FWFT). It also adds a fill-level output, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between a producer and consumer sharing one clock, e.g. in front of the read side of a datapath stage.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH words
- FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- Flush  in  1  synchronous clear of FIFO state
- DataIn  in  DATA_WIDTH  write data
- Wr_enable  in  1  write request
- Read_enable  in  1  read request (pop in FWFT)
- AlmostFull_level  in  ADDR_WIDTH+1  almost-full threshold
- AlmostEmpty_level  in  ADDR_WIDTH+1  almost-empty threshold
- DataOut  out  DATA_WIDTH  read data
- Level  out  ADDR_WIDTH+1  words stored, 0..DEPTH
- Empty, Full  out  1  Level==0 / Level==DEPTH
- AlmostFull  out  1  Level >= AlmostFull_level
- AlmostEmpty  out  1  Level <= AlmostEmpty_level
- Overflow, Underflow  out  1  sticky error flags

## Operation
- Read is accepted if Read_enable is high and Empty is low.
- Write is accepted if Wr_enable is high and either Full is low or a read is accepted in the same cycle. This makes simultaneous read and write on a full FIFO legal.
- Rejected write: no storage, no pointer move, Overflow set (sticky).
- Rejected read: no pointer move, DataOut held, Underflow set (sticky).
- Simultaneous read and write on an empty FIFO: the write is accepted and the read is rejected (Underflow set).
- Level changes by +1 for a write only, -1 for a read only, and 0 for both or neither. Level is never out of the range 0..DEPTH.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH. Level is the sole source of Full and Empty.
- FWFT=0: DataOut is a register loaded with the head word on an accepted read and holds otherwise.
- FWFT=1: DataOut = memory at the read pointer and is valid whenever Empty=0. An accepted read advances to the next word.
- Flush takes priority over rd/wr in the same cycle. It zeroes the pointers, Level, Overflow and Underflow, and zeroes DataOut when FWFT=0. Requests in a flush cycle are ignored and do not set error flags.
- The flags are combinational from registered Level and the threshold inputs. Thresholds may change at any time and take effect immediately.
- Memory contents are not cleared by rst or Flush.

## Timing
- Reset values: Level=0, Empty=1, Full=0, AlmostEmpty=1, Overflow=0, Underflow=0.
- Reset values, continued: AlmostFull=(AlmostFull_level==0), DataOut=0 when FWFT=0 (DataOut is don't-care while Empty=1 when FWFT=1).
- rst asserted mid-operation clears all state asynchronously. Operation resumes on the first edge after deassertion.
- Write accepted at edge N: Level, Empty and Full update after edge N. When FWFT=1, DataOut shows the word after edge N if it became the head.
- Read accepted at edge N with FWFT=0: DataOut holds the word after edge N (1-cycle latency).
- Sustained throughput: one write and one read per cycle.
- Overflow and Underflow assert after the edge of the offending request.

## Structure
- The shared package fifo_pkg holds the localparams DEPTH and LEVEL_W = ADDR_WIDTH+1, plus the mode encodings for FWFT.
- Sub-module fifo_mem: dual-port register array, DEPTH x DATA_WIDTH, with synchronous write and asynchronous read by address. It is reused by both modes.
- The top level holds the pointers, Level counter, accept logic, flags and the FWFT=0 output register.

## Test plan
All scenarios use DATA_WIDTH=8 and ADDR_WIDTH=5 (DEPTH=32).
- Reset with Flush=0 and thresholds AF=28, AE=3 -> Empty=1, Full=0, Level=0, AlmostEmpty=1, AlmostFull=0, DataOut=0, Overflow=0, Underflow=0.
- FWFT=0: write 0x55 then 0x81, then read twice -> DataOut=0x55 after the first read edge and 0x81 after the second; Empty=1 after the second read; read again -> Underflow=1.
- Write 0..31 -> Full=1 and Level=32 after the 32nd write; write 0xAA -> Overflow=1, Level=32; drain -> values 0..31 in order, no 0xAA, Empty=1.
- With Full=1, assert rd and wr (0x77) for 1 cycle -> Level=32, Full=1, no Overflow; 0x77 is read last after draining.
- With AF=28 and AE=3, fill word by word -> AlmostEmpty drops at Level=4 and AlmostFull rises at Level=28; reverse on drain.
- FWFT=1: write 0x3C -> Empty=0 and DataOut=0x3C one cycle later with no read; write 5 more, then Flush with rd+wr high -> Level=0, Empty=1, errors clear, no flag set.
